rom_read_sequencer: RTL and testbench
=====================================

# rom_read_sequencer

Two-requester controller for the team's single-port synchronous 4-word ROM. It arbitrates read bursts round-robin and sequences wrapping ROM addresses, one per cycle. It returns tagged read data with a last-beat marker. The ROM stays external; this block drives its address and enable and consumes its registered data output.

## Interface
Parameters:
- ADDR_W, 2: ROM address width (ROM depth = 2**ADDR_W)
- DATA_W, 4: ROM word width
- LEN_W, 2: burst-length field width; the field encodes length minus 1

Ports:
- clk  input  1  single clock, all logic on posedge
- rst  input  1  synchronous, active-high reset
- req_valid  input  2  per-requester request valid
- req_addr0 / req_addr1  input  ADDR_W  start address per requester
- req_len0 / req_len1  input  LEN_W  burst length minus 1 (0 means 1 word, 3 means 4 words)
- req_ready  output  2  one-hot acceptance pulse, combinational
- rom_en  output  1  ROM read issued this cycle
- rom_addr  output  ADDR_W  ROM address
- rom_data  input  DATA_W  ROM registered output, valid the cycle after issue
- rsp_valid  output  1  response beat valid
- rsp_id  output  1  requester that owns the beat
- rsp_last  output  1  final beat of the burst
- rsp_data  output  DATA_W  equals rom_data; qualified by rsp_valid

## Operation
- Two states:
  - IDLE: accepts a request.
  - BURST: issues the remaining beats.
- IDLE behaviour:
  - No req_valid: rom_en=0.
  - Request present: grant g. If only one valid, g is that one; if both, g is the requester that was not last granted.
  - Same cycle: req_ready[g]=1, rom_en=1, rom_addr=req_addr_g.
  - Latch owner=g, cur_addr=req_addr_g+1, remaining=req_len_g, last_grant=g.
  - If req_len_g==0, stay in IDLE; the beat is last. Otherwise go to BURST.
- BURST behaviour:
  - Each cycle: rom_en=1, rom_addr=cur_addr.
  - Then cur_addr increments and remaining decrements.
  - The beat issued when remaining==1 is last; state returns to IDLE.
  - req_ready=0 throughout BURST.
- Address arithmetic is modulo 2**ADDR_W: a start of 3 with len 3 yields addresses 3,0,1,2.
- Response pipeline registers issue (rom_en), owner and is_last, then presents them the next cycle as rsp_valid, rsp_id, rsp_last.
- No response backpressure: consumers must sink one beat per cycle.
- Requester rules:
  - Requesters hold addr and len stable while valid is high and ready is low.
  - Deasserting valid before ready is legal; the request is simply not taken.
  - A request that is not granted is never lost; it wins the next IDLE decision by round-robin.

## Timing
- Reset values:
  - state=IDLE, last_grant=1 (requester 0 wins the first tie).
  - rsp_valid=0, rsp_id=0, rsp_last=0.
  - req_ready=0 and rom_en=0 while rst is high.
- Read latency: 1 cycle from issue (rom_en) to rsp_valid.
- Burst of L words accepted in cycle N:
  - Issues in N through N+L-1.
  - Responses in N+1 through N+L; rsp_last in N+L.
  - Block is in IDLE in cycle N+L and can accept again. ROM utilization is 100%.
- Single-word requests from alternating requesters are accepted back-to-back, one per cycle.
- Reset mid-burst: the burst is aborted. rsp_valid is 0 from the cycle after rst is sampled high, so the in-flight beat is dropped, and no further beats follow.
- Simultaneous requests when the block becomes IDLE: round-robin applies; the loser sees ready exactly L_winner cycles later, at the earliest.

## Structure
- Package rom_seq_pkg holds:
  - state encoding localparams S_IDLE and S_BURST
  - default ADDR_W, DATA_W, LEN_W
- Sub-module rr_arb2: 2-way round-robin grant. Inputs are req[1:0], last_grant and an enable. Output is one-hot gnt. It is combinational, and the last_grant register lives in the parent.
- ROM instantiated only in the testbench, not inside this block.

## Test plan
Bench ROM image: addr0=0xE, addr1=0x2, addr2=0xF, addr3=0x4.
- Single read: req0 valid with addr 2, len 0 -> ready0 the same cycle; next cycle rsp_valid=1, id=0, data=0xF, last=1.
- Wrapping burst: req1 valid with addr 3, len 3 -> rom_addr sequence 3,0,1,2; rsp_data 0x4,0xE,0x2,0xF with id=1; rsp_last only on 0xF; ready1 asserted once.
- Contention out of reset: both valid at the same time, req0 addr 0 len 1, req1 addr 1 len 0 -> req0 granted first (data 0xE,0x2); req1 granted 2 cycles later (data 0x2).
- Fairness: both hold valid with len 0 for 6 cycles -> grants alternate 0,1,0,1,0,1 with no idle cycles.
- Reset mid-burst: rst asserted during the 2nd beat of a len-3 burst -> rsp_valid 0 from the next cycle; state IDLE; a new req0 after reset is served normally.
- Abandoned request: req1 valid during req0's burst, then dropped before the block returns to IDLE -> req1 never receives ready and no id=1 response appears.

Source files
------------

// File: rtl/rom_seq_pkg.sv
// Shared definitions for the ROM read sequencer: FSM state encoding and
// default geometry of the external ROM and the burst-length field.
package rom_seq_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_e;

  localparam int DEF_ADDR_W = 2;
  localparam int DEF_DATA_W = 4;
  localparam int DEF_LEN_W  = 2;

endpackage

// File: rtl/rom_read_sequencer_if.sv
// Bundles the requester handshake, the ROM port and the response stream.
// The sequencer uses the slave modport; requesters, ROM and consumers use master.
interface rom_read_sequencer_if
  import rom_seq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
);

  logic [1:0]        req_valid;
  logic [ADDR_W-1:0] req_addr0;
  logic [ADDR_W-1:0] req_addr1;
  logic [LEN_W-1:0]  req_len0;
  logic [LEN_W-1:0]  req_len1;
  logic [1:0]        req_ready;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              rsp_valid;
  logic              rsp_id;
  logic              rsp_last;
  logic [DATA_W-1:0] rsp_data;

  modport slave (
    input  req_valid, req_addr0, req_addr1, req_len0, req_len1, rom_data,
    output req_ready, rom_en, rom_addr, rsp_valid, rsp_id, rsp_last, rsp_data
  );

  modport master (
    output req_valid, req_addr0, req_addr1, req_len0, req_len1, rom_data,
    input  req_ready, rom_en, rom_addr, rsp_valid, rsp_id, rsp_last, rsp_data
  );

endinterface

// File: rtl/rom_read_sequencer_rr_arb2.sv
// Two-way round-robin grant. Purely combinational; the parent owns the
// last_grant register and updates it only when a grant is actually taken.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] gnt
);

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt = last_grant ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

endmodule

// File: rtl/rom_read_sequencer.sv
// Arbitrates two requesters onto a single-port synchronous ROM, issues one
// wrapping address per cycle and returns tagged beats one cycle later.
module rom_read_sequencer
  import rom_seq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input logic                  clk,
  input logic                  rst,
  rom_read_sequencer_if.slave  bus
);

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic              rsp_last_q, rsp_last_d;

  logic [1:0]        gnt;
  logic              arb_en;
  logic              sel;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;
  logic              issue;
  logic              issue_id;
  logic              issue_last;
  logic [ADDR_W-1:0] issue_addr;
  logic [DATA_W-1:0] rom_word;

  // Arbitration is only meaningful in IDLE; holding it off during reset
  // keeps req_ready and rom_en low while rst is high.
  assign arb_en = (state_q == S_IDLE) && !rst;

  rr_arb2 u_arb (
    .req        (bus.req_valid),
    .last_grant (last_grant_q),
    .en         (arb_en),
    .gnt        (gnt)
  );

  assign sel      = gnt[1];
  assign sel_addr = sel ? bus.req_addr1 : bus.req_addr0;
  assign sel_len  = sel ? bus.req_len1  : bus.req_len0;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    cur_addr_d   = cur_addr_q;
    remain_d     = remain_q;
    issue        = 1'b0;
    issue_id     = owner_q;
    issue_last   = 1'b0;
    issue_addr   = cur_addr_q;

    case (state_q)
      S_IDLE: begin
        if (gnt != 2'b00) begin
          issue        = 1'b1;
          issue_id     = sel;
          issue_addr   = sel_addr;
          issue_last   = (sel_len == '0);
          owner_d      = sel;
          cur_addr_d   = sel_addr + ADDR_W'(1);
          remain_d     = sel_len;
          last_grant_d = sel;
          if (sel_len != '0) begin
            state_d = S_BURST;
          end
        end
      end
      S_BURST: begin
        if (!rst) begin
          issue      = 1'b1;
          issue_last = (remain_q == LEN_W'(1));
          cur_addr_d = cur_addr_q + ADDR_W'(1);
          remain_d   = remain_q - LEN_W'(1);
          if (remain_q == LEN_W'(1)) begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    rsp_valid_d = issue;
    rsp_id_d    = issue_id;
    rsp_last_d  = issue_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      cur_addr_q   <= '0;
      remain_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      cur_addr_q   <= cur_addr_d;
      remain_q     <= remain_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_last_q   <= rsp_last_d;
    end
  end

  assign rom_word      = bus.rom_data;
  assign bus.req_ready = gnt;
  assign bus.rom_en    = issue;
  assign bus.rom_addr  = issue_addr;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.rsp_data  = rom_word;

endmodule

// File: tb/tb_rom_read_sequencer.sv
// Bench for rom_read_sequencer: a behavioural beat-queue model predicts every
// cycle's grant, ROM issue and response under directed and random traffic.
module tb_rom_read_sequencer;

  logic clk = 1'b0;
  logic rst;

  rom_read_sequencer_if #(.ADDR_W(2), .DATA_W(4), .LEN_W(2)) bus ();

  rom_read_sequencer #(.ADDR_W(2), .DATA_W(4), .LEN_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [3:0] rom_img [4] = '{4'hE, 4'h2, 4'hF, 4'h4};

  // External single-port ROM with a registered output.
  always @(posedge clk) begin
    if (rst) begin
      bus.rom_data <= 4'h0;
    end else if (bus.rom_en) begin
      bus.rom_data <= rom_img[bus.rom_addr];
    end
  end

  int checks   = 0;
  int failures = 0;

  bit   [1:0] r_v;
  logic [1:0] r_a [2];
  logic [1:0] r_l [2];

  logic [1:0] q_addr [$];
  bit         q_id   [$];
  bit         q_last [$];
  bit         m_last_g  = 1'b1;
  bit         e_rv      = 1'b0;
  bit         e_rid     = 1'b0;
  bit         e_rlast   = 1'b0;
  logic [3:0] e_rdata   = 4'h0;
  bit         after_rst = 1'b1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus();
    bus.req_valid = r_v;
    bus.req_addr0 = r_a[0];
    bus.req_addr1 = r_a[1];
    bus.req_len0  = r_l[0];
    bus.req_len1  = r_l[1];
  endtask

  // One clock cycle: predict from the request/beat model, compare at the
  // falling edge, then commit the model at the rising edge.
  task automatic stepCycle();
    logic [1:0] e_ready;
    bit         e_en;
    logic [1:0] e_addr;
    bit         i_id, i_last;
    int         g, a, l;
    e_ready = 2'b00; e_en = 1'b0; e_addr = 2'b00; i_id = 1'b0; i_last = 1'b0; g = -1;
    applyStimulus();
    @(negedge clk);
    if (!rst) begin
      if (q_addr.size() == 0 && (r_v[0] || r_v[1])) begin
        if (r_v[0] && r_v[1]) g = m_last_g ? 0 : 1;
        else                  g = r_v[0] ? 0 : 1;
        e_ready[g] = 1'b1;
        a = int'(r_a[g]);
        l = int'(r_l[g]);
        for (int i = 0; i <= l; i++) begin
          q_addr.push_back(2'((a + i) % 4));
          q_id.push_back(g[0]);
          q_last.push_back(i == l);
        end
        m_last_g = g[0];
      end
      if (q_addr.size() > 0) begin
        e_en   = 1'b1;
        e_addr = q_addr.pop_front();
        i_id   = q_id.pop_front();
        i_last = q_last.pop_front();
      end
    end
    checkOutput("req_ready", 32'(bus.req_ready), 32'(e_ready));
    checkOutput("rom_en", 32'(bus.rom_en), 32'(e_en));
    if (e_en) checkOutput("rom_addr", 32'(bus.rom_addr), 32'(e_addr));
    checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
    if (e_rv || after_rst) begin
      checkOutput("rsp_id", 32'(bus.rsp_id), 32'(e_rid));
      checkOutput("rsp_last", 32'(bus.rsp_last), 32'(e_rlast));
    end
    if (e_rv) checkOutput("rsp_data", 32'(bus.rsp_data), 32'(e_rdata));
    if (rst) begin
      q_addr.delete(); q_id.delete(); q_last.delete();
      m_last_g = 1'b1; e_rv = 1'b0; e_rid = 1'b0; e_rlast = 1'b0; after_rst = 1'b1;
    end else begin
      e_rv = e_en; e_rid = i_id; e_rlast = i_last; e_rdata = rom_img[e_addr]; after_rst = 1'b0;
    end
    @(posedge clk);
    #1;
    if (g >= 0) r_v[g] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    r_v = 2'b00;
    r_a[0] = 2'd0; r_a[1] = 2'd0; r_l[0] = 2'd0; r_l[1] = 2'd0;
    applyStimulus();
    @(posedge clk);
    #1;
    stepCycle();
    rst = 1'b0;

    // Single read of address 2.
    r_v[0] = 1'b1; r_a[0] = 2'd2; r_l[0] = 2'd0;
    repeat (3) stepCycle();

    // Wrapping four-beat burst from address 3.
    r_v[1] = 1'b1; r_a[1] = 2'd3; r_l[1] = 2'd3;
    repeat (6) stepCycle();

    // Contention straight out of reset.
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    r_v = 2'b11; r_a[0] = 2'd0; r_l[0] = 2'd1; r_a[1] = 2'd1; r_l[1] = 2'd0;
    repeat (5) stepCycle();

    // Fairness with both requesters continuously asking for single words.
    for (int i = 0; i < 6; i++) begin
      r_v = 2'b11; r_l[0] = 2'd0; r_l[1] = 2'd0;
      r_a[0] = 2'($urandom_range(0, 3)); r_a[1] = 2'($urandom_range(0, 3));
      stepCycle();
    end
    r_v = 2'b00;
    stepCycle();

    // Reset during the second beat of a burst, then a fresh request.
    r_v[0] = 1'b1; r_a[0] = 2'd1; r_l[0] = 2'd3;
    stepCycle();
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    stepCycle();
    r_v[0] = 1'b1; r_a[0] = 2'd2; r_l[0] = 2'd1;
    repeat (4) stepCycle();

    // Requester 1 gives up before the burst ends.
    r_v[0] = 1'b1; r_a[0] = 2'd1; r_l[0] = 2'd3;
    stepCycle();
    r_v[1] = 1'b1; r_a[1] = 2'd2; r_l[1] = 2'd0;
    repeat (2) stepCycle();
    r_v[1] = 1'b0;
    repeat (4) stepCycle();

    // Random traffic with occasional resets and abandoned requests.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (r_v[i]) begin
          if ($urandom_range(0, 9) == 0) r_v[i] = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
          r_v[i] = 1'b1;
          r_a[i] = 2'($urandom_range(0, 3));
          r_l[i] = 2'($urandom_range(0, 3));
        end
      end
      rst = ($urandom_range(0, 49) == 0);
      stepCycle();
    end
    rst = 1'b0;
    r_v = 2'b00;
    repeat (6) stepCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
